elevator_controller_nfloor: RTL and testbench
=============================================

Name: elevator_controller_nfloor

Overview:
Parametrised N-floor elevator controller and the successor to the fixed four-floor controller. It latches one-hot floor requests into a pending register and serves them in SCAN (sweep) order. Travel time per floor and door dwell time are timed by counters. Moore outputs drive the car motor and door, and pending/busy status is exposed for a supervisor or display block.

Parameters:
FLOORS, 8, number of floors (2..16); floor indices 0..FLOORS-1.
FLOOR_W, 3, width of current_floor; must be >= clog2(FLOORS).
TRAVEL_CYCLES, 4, clock cycles to travel one floor (>=1).
DOOR_CYCLES, 6, clock cycles door stays open per stop (>=1).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
floor_request  in  FLOORS  request bits; any number may be high; level or pulse accepted; sampled every edge.
current_floor  out  FLOOR_W  floor the car is at, or last floor passed.
move_up  out  1  motor up.
move_down  out  1  motor down.
door_open  out  1  door open.
dir_up  out  1  current sweep direction (1=up).
pending  out  FLOORS  latched, unserved requests.
busy  out  1  high when state != IDLE or pending != 0.

Behaviour:
- One clock and one reset, as decided: clk, and rst synchronous active-high.
- Reset (rst=1 at an edge):
  - state=IDLE, current_floor=0, pending=0, dir_up=1, timers=0.
  - move_up=move_down=door_open=0, busy=0.
  - Reset overrides everything, including mid-travel or door open.
  - Car teleports to 0; this is a model-level simplification.
- Pending update every edge: pending <= (pending | floor_request) & ~served_mask.
  - served_mask is one-hot for the floor being served at that edge, else 0.
  - A request bit set on the same edge its floor is served is cleared; that request counts as served.
- Outputs are registered and are functions of state only:
  - MOVE_UP -> move_up=1.
  - MOVE_DOWN -> move_down=1.
  - DOOR -> door_open=1.
  - Never more than one of the three is high.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR.
- IDLE: evaluates the registered pending value.
  - pending[current_floor]=1 -> DOOR; clear that bit; load door timer.
  - Else if requests exist in the dir_up direction -> move that way.
  - Else if requests exist in the opposite direction -> flip dir_up and move.
  - Else stay in IDLE.
  - Latency: request high at edge k -> pending at k; action at edge k+1.
- MOVE_UP / MOVE_DOWN:
  - Travel counter counts TRAVEL_CYCLES cycles.
  - On the last cycle's edge, current_floor increments or decrements by 1.
  - At that same edge, if pending[new floor] -> DOOR and clear that bit.
  - Otherwise continue in the same direction; requests ahead must exist, because requests are never withdrawn.
  - current_floor never leaves 0..FLOORS-1.
  - A request for a floor already passed is left pending and served on the return sweep.
- DOOR: door_open high for exactly DOOR_CYCLES cycles.
  - A request for current_floor arriving while the door is open clears immediately and restarts the door timer (door hold).
  - On expiry, apply the IDLE decision rules.
  - Requests ahead in dir_up -> move directly, with no IDLE cycle.
  - Else reverse direction if requests exist behind.
  - Else go to IDLE.
- Simultaneous requests above and below while idle: dir_up breaks the tie (sticky; up after reset).
- Out-of-range request bits cannot exist, since the port width is FLOORS.

Test Plan:
- Reset: rst=1 for 2 cycles with floor_request=8'hFF -> current_floor=0, pending=0, all motion/door outputs 0, busy=0.
- Same-floor request: idle at 0, floor_request=8'h01 for 1 cycle -> door_open=1 from edge 2 for exactly 6 cycles, no motion, then idle with busy=0.
- Single trip: at 0, request floor 3 (8'h08) -> move_up for 12 cycles, current_floor steps 1,2,3 every 4 cycles, door_open 6 cycles, pending=0, back to IDLE.
- SCAN order: heading up to 6, at floor 3 request floors 5 and 1 -> stops at 5 then 6 going up, then dir_up=0 and stop at 1; move_up and move_down never both 1.
- Door hold: during a door-open period at floor 2, pulse request 8'h04 on door cycle 4 -> door timer restarts; door_open total = 4+6=10 cycles; bit never left set in pending.
- Reset mid-operation: while moving between floors 4 and 5 with pending=8'h81, assert rst for 1 cycle -> next edge current_floor=0, pending=0, outputs 0, state IDLE.

Source files
------------

// File: rtl/elevator_controller_nfloor.sv
// N-floor elevator controller: latches one-hot floor requests and serves them in SCAN order,
// with per-floor travel and door dwell timed by down-counters.
module elevator_controller_nfloor #(
    parameter int FLOORS        = 8,
    parameter int FLOOR_W       = 3,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FLOORS-1:0]  floor_request,
    output logic [FLOOR_W-1:0] current_floor,
    output logic               move_up,
    output logic               move_down,
    output logic               door_open,
    output logic               dir_up,
    output logic [FLOORS-1:0]  pending,
    output logic               busy
);

    localparam int TW = $clog2(TRAVEL_CYCLES + 1);
    localparam int DW = $clog2(DOOR_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;

    state_t             state, state_n;
    logic [FLOOR_W-1:0] floor_n, floor_step;
    logic               dir_n;
    logic [TW-1:0]      tcnt, tcnt_n;
    logic [DW-1:0]      dcnt, dcnt_n;
    logic [FLOORS-1:0]  served, req_all;
    logic [1:0]         pick;

    function automatic logic any_above(input logic [FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOORS; i++)
            if (i > int'(f) && p[i]) r = 1'b1;
        return r;
    endfunction

    function automatic logic any_below(input logic [FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOORS; i++)
            if (i < int'(f) && p[i]) r = 1'b1;
        return r;
    endfunction

    // Returns {go, up}: keep the sweep direction if work lies ahead, else reverse, else stop.
    function automatic logic [1:0] pick_dir(input logic [FLOORS-1:0] p, input logic [FLOOR_W-1:0] f,
                                            input logic dir);
        logic up_ok, dn_ok;
        up_ok = any_above(p, f);
        dn_ok = any_below(p, f);
        if (dir && up_ok)       return 2'b11;
        else if (!dir && dn_ok) return 2'b10;
        else if (up_ok)         return 2'b11;
        else if (dn_ok)         return 2'b10;
        else                    return 2'b00;
    endfunction

    assign req_all    = pending | floor_request;
    assign floor_step = (state == MOVE_UP) ? current_floor + FLOOR_W'(1) : current_floor - FLOOR_W'(1);
    assign busy       = (state != IDLE) || (|pending);

    always_comb begin
        state_n = state;
        floor_n = current_floor;
        dir_n   = dir_up;
        tcnt_n  = tcnt;
        dcnt_n  = dcnt;
        served  = '0;
        pick    = 2'b00;
        case (state)
            IDLE: begin
                if (pending[current_floor]) begin
                    served[current_floor] = 1'b1;
                    state_n = DOOR;
                    dcnt_n  = DW'(DOOR_CYCLES - 1);
                end else begin
                    pick = pick_dir(pending, current_floor, dir_up);
                end
            end
            DOOR: begin
                if (floor_request[current_floor]) begin
                    served[current_floor] = 1'b1;
                    dcnt_n = DW'(DOOR_CYCLES - 1);
                end else if (dcnt != '0) begin
                    dcnt_n = dcnt - DW'(1);
                end else begin
                    pick    = pick_dir(req_all, current_floor, dir_up);
                    state_n = IDLE;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (tcnt != '0) begin
                    tcnt_n = tcnt - TW'(1);
                end else begin
                    floor_n = floor_step;
                    if (req_all[floor_step]) begin
                        served[floor_step] = 1'b1;
                        state_n = DOOR;
                        dcnt_n  = DW'(DOOR_CYCLES - 1);
                    end else begin
                        pick    = pick_dir(req_all, floor_step, dir_up);
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (pick[1]) begin
            state_n = pick[0] ? MOVE_UP : MOVE_DOWN;
            dir_n   = pick[0];
            tcnt_n  = TW'(TRAVEL_CYCLES - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            current_floor <= '0;
            pending       <= '0;
            dir_up        <= 1'b1;
            tcnt          <= '0;
            dcnt          <= '0;
            move_up       <= 1'b0;
            move_down     <= 1'b0;
            door_open     <= 1'b0;
        end else begin
            state         <= state_n;
            current_floor <= floor_n;
            pending       <= req_all & ~served;
            dir_up        <= dir_n;
            tcnt          <= tcnt_n;
            dcnt          <= dcnt_n;
            move_up       <= (state_n == MOVE_UP);
            move_down     <= (state_n == MOVE_DOWN);
            door_open     <= (state_n == DOOR);
        end
    end

endmodule

// File: tb/tb_elevator_controller_nfloor.sv
// Directed bench for elevator_controller_nfloor with hand-computed cycle timelines.
module tb_elevator_controller_nfloor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] floor_request = 8'h00;
    logic [2:0] current_floor;
    logic       move_up, move_down, door_open, dir_up, busy;
    logic [7:0] pending;

    int tests = 0;
    int fails = 0;
    logic both_seen = 1'b0;

    elevator_controller_nfloor #(
        .FLOORS(8), .FLOOR_W(3), .TRAVEL_CYCLES(4), .DOOR_CYCLES(6)
    ) dut (
        .clk(clk), .rst(rst), .floor_request(floor_request),
        .current_floor(current_floor), .move_up(move_up), .move_down(move_down),
        .door_open(door_open), .dir_up(dir_up), .pending(pending), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (move_up && move_down) both_seen <= 1'b1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_door(input logic level, input int budget, input string name);
        int n;
        n = 0;
        while (door_open !== level && n < budget) begin
            tick();
            n++;
        end
        tests++;
        if (door_open !== level) begin
            fails++;
            $display("FAIL %s: door_open=%b after %0d cycles, required %b", name, door_open, n, level);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        floor_request = 8'hFF;
        tick();
        tick();
        tests++;
        if (current_floor !== 3'd0) begin fails++; $display("FAIL reset_floor: got %0d, required 0", current_floor); end
        tests++;
        if (pending !== 8'h00) begin fails++; $display("FAIL reset_pending: got %h, required 00", pending); end
        tests++;
        if ({move_up, move_down, door_open, busy} !== 4'b0000) begin
            fails++; $display("FAIL reset_outputs: got %b, required 0000", {move_up, move_down, door_open, busy});
        end
        tests++;
        if (dir_up !== 1'b1) begin fails++; $display("FAIL reset_dir: got %b, required 1", dir_up); end
        rst = 1'b0;
        floor_request = 8'h00;
        tick();
        tests++;
        if (busy !== 1'b0 || pending !== 8'h00) begin
            fails++; $display("FAIL reset_release: busy=%b pending=%h, required 0/00", busy, pending);
        end
    endtask

    task automatic test_same_floor();
        int n;
        logic moved;
        floor_request = 8'h01;
        tick();
        floor_request = 8'h00;
        tests++;
        if (pending !== 8'h01 || door_open !== 1'b0) begin
            fails++; $display("FAIL same_latency: pending=%h door=%b, required 01/0", pending, door_open);
        end
        tick();
        tests++;
        if (door_open !== 1'b1 || pending !== 8'h00) begin
            fails++; $display("FAIL same_door_open: door=%b pending=%h, required 1/00", door_open, pending);
        end
        n = 1;
        moved = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (move_up || move_down) moved = 1'b1;
            if (!door_open) break;
            n++;
        end
        tests++;
        if (n !== 6) begin fails++; $display("FAIL same_door_len: got %0d cycles, required 6", n); end
        tests++;
        if (moved !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL same_idle: moved=%b busy=%b, required 0/0", moved, busy);
        end
    endtask

    task automatic test_single_trip();
        int n;
        logic [2:0] exp_f;
        floor_request = 8'h08;
        tick();
        floor_request = 8'h00;
        tests++;
        if (move_up !== 1'b0 || door_open !== 1'b0) begin
            fails++; $display("FAIL trip_latency: move_up=%b door=%b, required 0/0", move_up, door_open);
        end
        for (int c = 2; c < 14; c++) begin
            tick();
            exp_f = 3'((c - 2) / 4);
            tests++;
            if (move_up !== 1'b1 || current_floor !== exp_f) begin
                fails++;
                $display("FAIL trip_edge%0d: move_up=%b floor=%0d, required 1/%0d", c, move_up, current_floor, exp_f);
            end
        end
        tick();
        tests++;
        if (door_open !== 1'b1 || move_up !== 1'b0 || current_floor !== 3'd3) begin
            fails++; $display("FAIL trip_arrive: door=%b move_up=%b floor=%0d, required 1/0/3", door_open, move_up, current_floor);
        end
        n = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!door_open) break;
            n++;
        end
        tests++;
        if (n !== 6) begin fails++; $display("FAIL trip_door_len: got %0d, required 6", n); end
        tests++;
        if (pending !== 8'h00 || busy !== 1'b0) begin
            fails++; $display("FAIL trip_idle: pending=%h busy=%b, required 00/0", pending, busy);
        end
    endtask

    task automatic test_scan();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        floor_request = 8'h40;
        tick();
        floor_request = 8'h00;
        repeat (13) tick();
        tests++;
        if (current_floor !== 3'd3 || move_up !== 1'b1) begin
            fails++; $display("FAIL scan_at3: floor=%0d move_up=%b, required 3/1", current_floor, move_up);
        end
        floor_request = 8'h22;
        tick();
        floor_request = 8'h00;
        tests++;
        if (pending !== 8'h62) begin fails++; $display("FAIL scan_pending: got %h, required 62", pending); end
        wait_door(1'b1, 40, "scan_stop5_wait");
        tests++;
        if (current_floor !== 3'd5 || dir_up !== 1'b1 || pending !== 8'h42) begin
            fails++; $display("FAIL scan_stop5: floor=%0d dir=%b pending=%h, required 5/1/42", current_floor, dir_up, pending);
        end
        wait_door(1'b0, 20, "scan_leave5_wait");
        tests++;
        if (move_up !== 1'b1) begin fails++; $display("FAIL scan_direct_up: move_up=%b, required 1", move_up); end
        wait_door(1'b1, 40, "scan_stop6_wait");
        tests++;
        if (current_floor !== 3'd6) begin fails++; $display("FAIL scan_stop6: floor=%0d, required 6", current_floor); end
        wait_door(1'b0, 20, "scan_leave6_wait");
        tests++;
        if (move_down !== 1'b1 || dir_up !== 1'b0) begin
            fails++; $display("FAIL scan_reverse: move_down=%b dir=%b, required 1/0", move_down, dir_up);
        end
        wait_door(1'b1, 60, "scan_stop1_wait");
        tests++;
        if (current_floor !== 3'd1 || pending !== 8'h00) begin
            fails++; $display("FAIL scan_stop1: floor=%0d pending=%h, required 1/00", current_floor, pending);
        end
        wait_door(1'b0, 20, "scan_close1_wait");
        tests++;
        if (busy !== 1'b0 || both_seen !== 1'b0) begin
            fails++; $display("FAIL scan_end: busy=%b both_moves=%b, required 0/0", busy, both_seen);
        end
    endtask

    task automatic test_door_hold();
        int n;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        floor_request = 8'h04;
        tick();
        floor_request = 8'h00;
        wait_door(1'b1, 40, "hold_open_wait");
        n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (door_open) n++;
        end
        floor_request = 8'h04;
        tick();
        floor_request = 8'h00;
        if (door_open) n++;
        tests++;
        if (pending !== 8'h00) begin fails++; $display("FAIL hold_pending: got %h, required 00", pending); end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!door_open) break;
            n++;
        end
        tests++;
        if (n !== 10) begin fails++; $display("FAIL hold_door_len: got %0d, required 10", n); end
        tests++;
        if (current_floor !== 3'd2 || pending !== 8'h00 || busy !== 1'b0) begin
            fails++; $display("FAIL hold_end: floor=%0d pending=%h busy=%b, required 2/00/0", current_floor, pending, busy);
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        floor_request = 8'h80;
        tick();
        floor_request = 8'h00;
        repeat (17) tick();
        floor_request = 8'h01;
        tick();
        floor_request = 8'h00;
        tests++;
        if (pending !== 8'h81 || current_floor !== 3'd4 || move_up !== 1'b1) begin
            fails++; $display("FAIL mid_setup: pending=%h floor=%0d move_up=%b, required 81/4/1", pending, current_floor, move_up);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (current_floor !== 3'd0 || pending !== 8'h00 || {move_up, move_down, door_open, busy} !== 4'b0000) begin
            fails++;
            $display("FAIL mid_reset: floor=%0d pending=%h outs=%b, required 0/00/0000",
                     current_floor, pending, {move_up, move_down, door_open, busy});
        end
        tick();
        tests++;
        if (busy !== 1'b0 || move_up !== 1'b0) begin
            fails++; $display("FAIL mid_idle: busy=%b move_up=%b, required 0/0", busy, move_up);
        end
    endtask

    initial begin
        test_reset();
        test_same_floor();
        test_single_trip();
        test_scan();
        test_door_hold();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
